// File: rtl/tmds_clk_pkg.sv
// Shared types and defaults for the TMDS PLL reset sequencer; pure declarations, no timing.
// Output decode lives here so the reset values and the per-state outputs cannot drift apart.
package tmds_clk_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    SER_REL   = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } state_e;

  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 50000;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_SER_DELAY      = 16;
  localparam int DEF_MAX_RETRY      = 4;

  localparam int RETRY_W = 3;

  typedef struct packed {
    logic pll_reset;
    logic ser_rst;
    logic pix_rst;
    logic ready;
    logic fail;
  } seq_out_t;

  function automatic seq_out_t decode_outputs(input state_e s);
    seq_out_t o;
    o = '{pll_reset: 1'b0, ser_rst: 1'b1, pix_rst: 1'b1, ready: 1'b0, fail: 1'b0};
    case (s)
      PLL_RST:   o.pll_reset = 1'b1;
      WAIT_LOCK: o.pll_reset = 1'b0;
      STABLE:    o.pll_reset = 1'b0;
      SER_REL:   o.ser_rst   = 1'b0;
      RUN: begin
        o.ser_rst = 1'b0;
        o.pix_rst = 1'b0;
        o.ready   = 1'b1;
      end
      FAIL: begin
        o.pll_reset = 1'b1;
        o.fail      = 1'b1;
      end
      default:   o.pll_reset = 1'b1;
    endcase
    return o;
  endfunction

  function automatic int max_of5(input int a, input int b, input int c, input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/tmds_pll_reset_seq_sync_2ff.sv
// Generic two-flop bit synchronizer, reset value 0; latency 2 cycles, no backpressure.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/tmds_pll_reset_seq.sv
// TMDS PLL power-up/recovery sequencer on the reference clock; outputs registered from next state, lock seen 2 cycles late.
// No backpressure. Optional lock-loss statistics under TMDS_PLL_LOSS_CNT_EN.
module tmds_pll_reset_seq
  import tmds_clk_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int SER_DELAY      = DEF_SER_DELAY,
  parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_lock,
  input  logic               retry_req,
  output logic               pll_reset,
  output logic               ser_rst,
  output logic               pix_rst,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef TMDS_PLL_LOSS_CNT_EN
  ,
  output logic [7:0]         loss_cnt,
  output logic               sticky_loss
`endif
);

  localparam int CNT_MAX = max_of5(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, SER_DELAY, MAX_RETRY);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0]   PLL_LAST   = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STB_LAST   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SER_LAST   = CNT_W'(SER_DELAY - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

  logic               lock_s;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [RETRY_W-1:0] retry_q, retry_d;
  seq_out_t           out_q, out_d;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      PLL_RST: begin
        if (cnt_q == PLL_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock beats a simultaneous timeout.
        if (lock_s) begin
          state_d = STABLE;
        end else if (cnt_q == TO_LAST) begin
          if (retry_q == RETRY_LAST) begin
            state_d = FAIL;
          end else begin
            state_d = PLL_RST;
            retry_d = retry_q + 1'b1;
          end
        end
      end
      STABLE: begin
        if (!lock_s)                state_d = WAIT_LOCK;
        else if (cnt_q == STB_LAST) state_d = SER_REL;
      end
      SER_REL: begin
        if (!lock_s)                state_d = PLL_RST;
        else if (cnt_q == SER_LAST) state_d = RUN;
      end
      RUN: begin
        if (!lock_s) state_d = PLL_RST;
      end
      FAIL: begin
        if (retry_req) begin
          state_d = PLL_RST;
          retry_d = '0;
        end
      end
      default: state_d = PLL_RST;
    endcase
    if (state_d == RUN && state_q != RUN) retry_d = '0;
    out_d = decode_outputs(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PLL_RST;
      cnt_q   <= '0;
      retry_q <= '0;
      out_q   <= decode_outputs(PLL_RST);
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      out_q   <= out_d;
      // Every transition is a state change, so this clears cnt on each entry.
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q inside {PLL_RST, WAIT_LOCK, STABLE, SER_REL}) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pll_reset = out_q.pll_reset;
  assign ser_rst   = out_q.ser_rst;
  assign pix_rst   = out_q.pix_rst;
  assign ready     = out_q.ready;
  assign fail      = out_q.fail;
  assign retry_cnt = retry_q;

`ifdef TMDS_PLL_LOSS_CNT_EN
  logic [7:0] loss_cnt_q;
  logic       sticky_q;
  logic       loss_evt;

  assign loss_evt = (state_q == RUN) && (state_d == PLL_RST);

  always_ff @(posedge clk) begin
    if (reset) begin
      loss_cnt_q <= '0;
      sticky_q   <= 1'b0;
    end else if (loss_evt) begin
      sticky_q <= 1'b1;
      if (loss_cnt_q != 8'hFF) loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign loss_cnt    = loss_cnt_q;
  assign sticky_loss = sticky_q;
`endif

endmodule

// File: tb/tb_tmds_pll_reset_seq.sv
// Directed bench for tmds_pll_reset_seq; expected outputs are queued per edge and checked as the run reaches that edge.
module tb_tmds_pll_reset_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       retry_req;
  logic       pll_reset;
  logic       ser_rst;
  logic       pix_rst;
  logic       ready;
  logic       fail;
  logic [2:0] retry_cnt;
`ifdef TMDS_PLL_LOSS_CNT_EN
  logic [7:0] loss_cnt;
  logic       sticky_loss;
`endif

  always #5 clk = ~clk;

  tmds_pll_reset_seq #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (20),
    .STABLE_CYCLES  (8),
    .SER_DELAY      (3),
    .MAX_RETRY      (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pll_lock    (pll_lock),
    .retry_req   (retry_req),
    .pll_reset   (pll_reset),
    .ser_rst     (ser_rst),
    .pix_rst     (pix_rst),
    .ready       (ready),
    .fail        (fail),
    .retry_cnt   (retry_cnt)
`ifdef TMDS_PLL_LOSS_CNT_EN
    ,
    .loss_cnt    (loss_cnt),
    .sticky_loss (sticky_loss)
`endif
  );

  int         checks   = 0;
  int         failures = 0;
  int         edge_n   = 0;
  int         q_edge[$];
  logic [7:0] q_val[$];
  string      q_tag[$];

  // Packed order: pll_reset, ser_rst, pix_rst, ready, fail, retry_cnt[2:0].
  function automatic logic [7:0] ex(input logic pr, input logic sr, input logic xr,
                                    input logic rdy, input logic f, input logic [2:0] rc);
    return {pr, sr, xr, rdy, f, rc};
  endfunction

  task automatic expect_at(input int e, input string tag, input logic [7:0] v);
    q_edge.push_back(e);
    q_val.push_back(v);
    q_tag.push_back(tag);
  endtask

  task automatic compare_due();
    logic [7:0] obs;
    logic [7:0] exp_v;
    string      tag;
    while (q_edge.size() > 0 && q_edge[0] <= edge_n) begin
      void'(q_edge.pop_front());
      exp_v = q_val.pop_front();
      tag   = q_tag.pop_front();
      obs   = {pll_reset, ser_rst, pix_rst, ready, fail, retry_cnt};
      checks++;
      assert (obs === exp_v) else begin
        failures++;
        $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, exp_v);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
    compare_due();
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) step();
  endtask

  task automatic drain();
    checks++;
    assert (q_edge.size() == 0) else begin
      failures++;
      $error("FAIL sb_drain observed=%0d expected=0 pending", q_edge.size());
    end
    q_edge.delete();
    q_val.delete();
    q_tag.delete();
  endtask

  // Edge 0 is the last edge that samples reset high.
  task automatic do_reset();
    reset     = 1'b1;
    pll_lock  = 1'b0;
    retry_req = 1'b0;
    edge_n    = -3;
    step();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    pll_lock  = 1'b0;
    retry_req = 1'b0;

    // Clean bring-up, then lock loss in RUN.
    expect_at(0,  "rst_vals",    ex(1, 1, 1, 0, 0, 0));
    expect_at(3,  "pllrst_hold", ex(1, 1, 1, 0, 0, 0));
    expect_at(4,  "pllrst_rel",  ex(0, 1, 1, 0, 0, 0));
    expect_at(20, "stable_hold", ex(0, 1, 1, 0, 0, 0));
    expect_at(21, "ser_rel",     ex(0, 0, 1, 0, 0, 0));
    expect_at(23, "pix_hold",    ex(0, 0, 1, 0, 0, 0));
    expect_at(24, "run",         ex(0, 0, 0, 1, 0, 0));
    expect_at(32, "loss_lat",    ex(0, 0, 0, 1, 0, 0));
    expect_at(33, "loss_run",    ex(1, 1, 1, 0, 0, 0));
    do_reset();
    run_to(10);
    pll_lock = 1'b1;
    run_to(30);
    pll_lock = 1'b0;
    run_to(33);
`ifdef TMDS_PLL_LOSS_CNT_EN
    checks++;
    assert (loss_cnt === 8'd1) else begin
      failures++;
      $error("FAIL loss_cnt observed=%0d expected=1", loss_cnt);
    end
    checks++;
    assert (sticky_loss === 1'b1) else begin
      failures++;
      $error("FAIL sticky_loss observed=%b expected=1", sticky_loss);
    end
`endif
    drain();

    // Single timeout; a stray retry_req in WAIT_LOCK must be ignored.
    expect_at(23, "to1_wait",   ex(0, 1, 1, 0, 0, 0));
    expect_at(24, "to1_rerst",  ex(1, 1, 1, 0, 0, 1));
    expect_at(27, "to1_hold",   ex(1, 1, 1, 0, 0, 1));
    expect_at(28, "to1_wait2",  ex(0, 1, 1, 0, 0, 1));
    expect_at(50, "to1_stable", ex(0, 1, 1, 0, 0, 1));
    expect_at(51, "to1_ser",    ex(0, 0, 1, 0, 0, 1));
    expect_at(54, "to1_run",    ex(0, 0, 0, 1, 0, 0));
    do_reset();
    run_to(10);
    retry_req = 1'b1;
    step();
    retry_req = 1'b0;
    run_to(40);
    pll_lock = 1'b1;
    run_to(54);
    drain();

    // Retries exhausted, then recovery through retry_req.
    expect_at(47,  "ex_wait",      ex(0, 1, 1, 0, 0, 1));
    expect_at(48,  "ex_fail",      ex(1, 1, 1, 0, 1, 1));
    expect_at(100, "ex_fail_hold", ex(1, 1, 1, 0, 1, 1));
    expect_at(101, "ex_retry",     ex(1, 1, 1, 0, 0, 0));
    expect_at(104, "ex_pllrst",    ex(1, 1, 1, 0, 0, 0));
    expect_at(105, "ex_wait2",     ex(0, 1, 1, 0, 0, 0));
    do_reset();
    run_to(100);
    retry_req = 1'b1;
    step();
    retry_req = 1'b0;
    run_to(105);
    drain();

    // Two-cycle lock glitch while counting in STABLE.
    expect_at(13, "gl_stable",  ex(0, 1, 1, 0, 0, 0));
    expect_at(21, "gl_no_rel",  ex(0, 1, 1, 0, 0, 0));
    expect_at(28, "gl_restart", ex(0, 1, 1, 0, 0, 0));
    expect_at(29, "gl_ser",     ex(0, 0, 1, 0, 0, 0));
    expect_at(32, "gl_run",     ex(0, 0, 0, 1, 0, 0));
    do_reset();
    run_to(10);
    pll_lock = 1'b1;
    run_to(16);
    pll_lock = 1'b0;
    run_to(18);
    pll_lock = 1'b1;
    run_to(32);
    drain();

    // Reset asserted during SER_REL.
    expect_at(22, "rs_ser",    ex(0, 0, 1, 0, 0, 0));
    expect_at(23, "rs_vals",   ex(1, 1, 1, 0, 0, 0));
    expect_at(26, "rs_pllrst", ex(1, 1, 1, 0, 0, 0));
    expect_at(27, "rs_wait",   ex(0, 1, 1, 0, 0, 0));
    do_reset();
    run_to(10);
    pll_lock = 1'b1;
    run_to(22);
    reset = 1'b1;
    run_to(23);
    reset = 1'b0;
    checks++;
    assert (dut.state_q === tmds_clk_pkg::PLL_RST) else begin
      failures++;
      $error("FAIL rs_state observed=%0d expected=%0d", dut.state_q, tmds_clk_pkg::PLL_RST);
    end
    run_to(27);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
